wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Completion side of the issue/ROB interface. Accepts results from NUM_FU functional units through per-FU
//  valid/ready handshakes and buffers each FU's results in a small FIFO. Arbitrates the buffered results onto
//  the single ROB write-back port (WB_valid/WB_data/WB_rob_idx). On mispredict, discards buffered results
//  younger than the mispredicted ROB entry; the ROB frees those entries in the same cycle.
// PARAMETERS
//  NUM_FU     5   number of functional units; fu_ready is also the issue stage's EXE_ready vector
//  DATA_W     32  result width
//  ROB_IDX_W  3   ROB index width; ROB has 2**ROB_IDX_W entries
//  DEPTH      2   entries per FU FIFO (power of 2, >=1)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  reset
//  fu_valid     in   NUM_FU             FU i presents a result
//  fu_ready     out  NUM_FU             FU i FIFO can accept
//  fu_data      in   NUM_FU*DATA_W      result of FU i in slice i
//  fu_rob_idx   in   NUM_FU*ROB_IDX_W   ROB index of FU i result
//  rob_head     in   ROB_IDX_W          current ROB head (oldest entry)
//  mispredict   in   1                  branch mispredict this cycle
//  mis_rob_idx  in   ROB_IDX_W          ROB index of the mispredicted branch
//  WB_valid     out  1                  write-back valid to ROB
//  WB_data      out  DATA_W             write-back data
//  WB_rob_idx   out  ROB_IDX_W          write-back ROB index
//  pending_cnt  out  8                  total buffered results (debug)
// BEHAVIOUR
//  - Reset: rst is synchronous, active-high; clock is clk. Reset empties all FIFOs and sets the RR pointer to 0.
//    After reset: WB_valid=0, WB_data=0, WB_rob_idx=0, pending_cnt=0, fu_ready=all 1.
//  - fu_ready[i] = (count_i < DEPTH). It depends only on registered state; there is no combinational path from fu_valid.
//  - Push: FU i pushes when fu_valid[i] && fu_ready[i] && !flush_in_i.
//  - Age: age(x) = (x - rob_head) mod 2**ROB_IDX_W. "Younger" means age(x) > age(mis_rob_idx).
//    The mispredicted entry itself is kept.
//  - Flush (mispredict=1):
//    - Each entry whose ROB index is younger than mis_rob_idx is removed at the clock edge. This applies to every
//      buffered entry and to any entry being pushed in that cycle.
//    - Surviving entries keep their FIFO order and are compacted.
//    - A flushed FIFO head is not eligible for selection in that cycle.
//  - Select:
//    - Each cycle, one eligible FIFO head is chosen (default: round-robin).
//    - The search starts at the FU after the last granted FU, wrapping from NUM_FU-1 to 0.
//    - The winner is popped, and the RR pointer advances only on a grant.
//  - Output register: WB_* is loaded on the edge after selection. If nothing is selected, WB_valid=0 and
//    WB_data/WB_rob_idx hold their values.
//    - Latency: result pushed at edge N into an empty FIFO with no competition -> WB_valid high in the cycle after edge N+1.
//    - Minimum latency is 1 cycle after acceptance.
//  - Push and pop on the same FIFO in the same cycle are both allowed. When the FIFO is full, ready=0, so no push occurs.
//  - Throughput is 1 write-back per cycle. The ROB has no back-pressure; WB_valid is never stalled.
//  - A WB_* register already loaded when mispredict arrives is not cancelled. The ROB flush has priority for
//    that index on that edge.
//  - pending_cnt = sum of all FIFO counts after push/pop/flush, registered.
//  - Reset mid-operation discards all buffered results, and no WB_valid pulse follows.
// CONFIGURATION
//  - WB_OLDEST_FIRST_EN defined: select the eligible head with the smallest age(rob_idx) relative to rob_head.
//    ROB indices are unique, so there are no ties. The RR pointer is unused and held at 0.
//  - Undefined: round-robin selection as above.
// TESTING
//  1. Reset, then FU0 pushes data=0xA5, idx=2 -> next cycle WB_valid=1, WB_data=0xA5, WB_rob_idx=2; fu_ready=5'b11111 throughout.
//  2. FU1 and FU3 push idx 4 and 5 in the same cycle, RR pointer=0
//     - Default: FU1 then FU3 on consecutive cycles.
//     - With WB_OLDEST_FIRST_EN, rob_head=5: idx 5 first, then idx 4.
//  3. FU2 pushes 3 results back-to-back while FU0 wins every arbitration -> fu_ready[2]=0 after 2 pushes;
//     the third result is held by the FU until ready=1.
//  4. rob_head=6, buffered idx {7,0,1}, mispredict with mis_rob_idx=7 -> idx 0 and 1 dropped, idx 7 written back;
//     pending_cnt drops from 3 to 1.
//  5. Mispredict in the same cycle as a push of a younger idx -> that push is discarded; fu_ready stays 1.
//  6. Assert rst with 4 entries buffered -> WB_valid=0 from the next cycle, pending_cnt=0, and no later write-back.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Completion-side bundle between functional units, the ROB and the write-back arbiter.
// The FU/ROB side uses the master modport; the arbiter uses the slave modport.
interface wb_arbiter_if #(
    parameter int NUM_FU    = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 3
);
    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU*DATA_W-1:0]    fu_data;
    logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx;
    logic [ROB_IDX_W-1:0]        rob_head;
    logic                        mispredict;
    logic [ROB_IDX_W-1:0]        mis_rob_idx;
    logic                        WB_valid;
    logic [DATA_W-1:0]           WB_data;
    logic [ROB_IDX_W-1:0]        WB_rob_idx;
    logic [7:0]                  pending_cnt;

    modport master (
        output fu_valid, fu_data, fu_rob_idx,
        output rob_head, mispredict, mis_rob_idx,
        input  fu_ready, WB_valid, WB_data, WB_rob_idx, pending_cnt
    );

    modport slave (
        input  fu_valid, fu_data, fu_rob_idx,
        input  rob_head, mispredict, mis_rob_idx,
        output fu_ready, WB_valid, WB_data, WB_rob_idx, pending_cnt
    );
endinterface

// File: rtl/wb_arbiter.sv
// Per-FU result FIFOs arbitrated onto the single ROB write-back port, with mispredict flush.
// WB_OLDEST_FIRST_EN selects the oldest eligible head instead of round-robin.
module wb_arbiter #(
    parameter int NUM_FU    = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 3,
    parameter int DEPTH     = 2
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] idx;
    } ent_t;

    ent_t mem_q [NUM_FU][DEPTH];
    ent_t mem_d [NUM_FU][DEPTH];
    ent_t in_ent [NUM_FU];

    logic [NUM_FU-1:0][DEPTH-1:0] vld_q, vld_d;
    logic [NUM_FU-1:0][DEPTH-1:0] young;
    logic [NUM_FU-1:0]            ready, push, pop, elig;
    logic [RW-1:0]                rr_q, rr_d;
    logic                         wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]            wb_data_q, wb_data_d;
    logic [ROB_IDX_W-1:0]         wb_idx_q, wb_idx_d;
    logic [7:0]                   pend_q, pend_d;
    logic [ROB_IDX_W-1:0]         mis_age;
    logic                         sel;
    int                           win;
    int                           k;
`ifdef WB_OLDEST_FIRST_EN
    logic [ROB_IDX_W-1:0]         best;
`endif

    function automatic logic [ROB_IDX_W-1:0] age(
        input logic [ROB_IDX_W-1:0] x,
        input logic [ROB_IDX_W-1:0] head
    );
        return x - head;
    endfunction

    // Entries are kept compacted at the low slots, so the top slot marks full.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = !vld_q[i][DEPTH-1];
        end
    end

    assign bus.fu_ready = ready;

    always_comb begin
        mis_age = age(bus.mis_rob_idx, bus.rob_head);
        young   = '0;
        push    = '0;
        elig    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            in_ent[i].data = bus.fu_data[i*DATA_W +: DATA_W];
            in_ent[i].idx  = bus.fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            for (int j = 0; j < DEPTH; j++) begin
                young[i][j] = bus.mispredict &&
                    (age(mem_q[i][j].idx, bus.rob_head) > mis_age);
            end
            push[i] = bus.fu_valid[i] && ready[i] && !(bus.mispredict &&
                (age(in_ent[i].idx, bus.rob_head) > mis_age));
            elig[i] = vld_q[i][0] && !young[i][0];
        end
    end

    always_comb begin
        sel = 1'b0;
        win = 0;
        pop = '0;
`ifdef WB_OLDEST_FIRST_EN
        best = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (elig[i] && (!sel ||
                age(mem_q[i][0].idx, bus.rob_head) < best)) begin
                sel  = 1'b1;
                win  = i;
                best = age(mem_q[i][0].idx, bus.rob_head);
            end
        end
        rr_d = '0;
`else
        // Search begins one past the last granted FU.
        for (int o = 1; o <= NUM_FU; o++) begin
            int c;
            c = int'(rr_q) + o;
            if (c >= NUM_FU) c = c - NUM_FU;
            if (!sel && elig[c]) begin
                sel = 1'b1;
                win = c;
            end
        end
        rr_d = sel ? RW'(win) : rr_q;
`endif
        if (sel) pop[win] = 1'b1;
        wb_valid_d = sel;
        wb_data_d  = sel ? mem_q[win][0].data : wb_data_q;
        wb_idx_d   = sel ? mem_q[win][0].idx  : wb_idx_q;
    end

    // Rebuild each FIFO from its survivors, then append the incoming push.
    always_comb begin
        mem_d  = mem_q;
        vld_d  = '0;
        pend_d = '0;
        k      = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            k = 0;
            for (int j = 0; j < DEPTH; j++) begin
                if (vld_q[i][j] && !(pop[i] && j == 0) && !young[i][j]) begin
                    mem_d[i][k] = mem_q[i][j];
                    vld_d[i][k] = 1'b1;
                    k = k + 1;
                end
            end
            if (push[i] && k < DEPTH) begin
                mem_d[i][k] = in_ent[i];
                vld_d[i][k] = 1'b1;
                k = k + 1;
            end
            pend_d = pend_d + 8'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            rr_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_idx_q   <= '0;
            pend_q     <= '0;
        end else begin
            vld_q      <= vld_d;
            rr_q       <= rr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_idx_q   <= wb_idx_d;
            pend_q     <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.WB_valid    = wb_valid_q;
    assign bus.WB_data     = wb_data_q;
    assign bus.WB_rob_idx  = wb_idx_q;
    assign bus.pending_cnt = pend_q;
endmodule
